// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared pipeline definitions for the fetch / stall control slice.
// Holds reset PC, control width, NOP encoding and the IF/ID record layout.
package fetch_stall_ctrl_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          CTRL_W_DEF   = 9;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          BCNT_W       = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Hazard-unit / EX redirect bundle into the fetch stall controller.
interface fetch_stall_ctrl_if;
  logic        hold;
  logic        repeat_i;
  logic        nop;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (output hold, repeat_i, nop, branch_taken, branch_target);
  modport slave  (input  hold, repeat_i, nop, branch_taken, branch_target);
endinterface

// File: rtl/fetch_stall_ctrl_ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module ifid_reg
  import fetch_stall_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  hold,
  input  ifid_t d,
  output ifid_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= IFID_EMPTY;
    else if (flush) q <= IFID_EMPTY;
    else if (!hold) q <= d;
  end
endmodule

// File: rtl/fetch_stall_ctrl.sv
// PC sequencing, IF/ID and ID/EX control with hazard-driven stalls, bubbles
// and branch redirect; a redirect overrides any concurrent stall request.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CTRL_W   = CTRL_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_stall_ctrl_if.slave   hz,
  input  logic [31:0]         imem_instr,
  input  logic [CTRL_W-1:0]   id_ctrl,
  output logic [31:0]         pc,
  output logic [31:0]         ifid_instr,
  output logic [31:0]         ifid_pc4,
  output logic                ifid_valid,
  output logic [CTRL_W-1:0]   idex_ctrl,
  output logic [BCNT_W-1:0]   bubble_cnt,
  output logic                stall_err
);
  logic [31:0] pc4;
  ifid_t       fetch_d, ifid_q;
  logic        bubble, stall_mixed;

  assign pc4         = pc + 32'd4;
  assign bubble      = hz.nop && !hz.branch_taken;
  assign stall_mixed = (hz.hold != hz.repeat_i) || (hz.repeat_i != hz.nop);

  always_comb begin
    fetch_d       = IFID_EMPTY;
    fetch_d.instr = imem_instr;
    fetch_d.pc4   = pc4;
    fetch_d.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pc <= RESET_PC;
    else if (hz.branch_taken)  pc <= hz.branch_target;
    else if (!hz.hold)         pc <= pc4;
  end

  ifid_reg u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (hz.branch_taken),
    .hold  (hz.repeat_i),
    .d     (fetch_d),
    .q     (ifid_q)
  );

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

  // Zeroed control is the bubble; an empty IF/ID also yields one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        idex_ctrl <= '0;
    else if (hz.branch_taken || hz.nop || !ifid_q.valid) idex_ctrl <= '0;
    else                                               idex_ctrl <= id_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_err  <= 1'b0;
    end else begin
      if (bubble && (bubble_cnt != {BCNT_W{1'b1}})) bubble_cnt <= bubble_cnt + 1'b1;
      if (stall_mixed) stall_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboarded random/directed bench for fetch_stall_ctrl against a
// cycle-level behavioural model of the fetch rules.
module tb_fetch_stall_ctrl;
  localparam int CW = 9;

  typedef struct {
    logic [31:0]   pc, instr, pc4;
    logic          valid;
    logic [CW-1:0] ctrl;
    logic [15:0]   cnt;
    logic          err;
  } exp_t;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [31:0]   imem_instr, pc, ifid_instr, ifid_pc4;
  logic [CW-1:0] id_ctrl, idex_ctrl;
  logic          ifid_valid, stall_err;
  logic [15:0]   bubble_cnt;

  fetch_stall_ctrl_if hz();

  fetch_stall_ctrl #(.RESET_PC(32'h0), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz), .imem_instr(imem_instr), .id_ctrl(id_ctrl),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .idex_ctrl(idex_ctrl), .bubble_cnt(bubble_cnt), .stall_err(stall_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_2468;
  endfunction
  assign imem_instr = mem_word(pc);

  exp_t m, expq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: each DUT edge (clock or async reset) with a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc", pc, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc4", ifid_pc4, e.pc4);
        chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        chk("idex_ctrl", 32'(idex_ctrl), 32'(e.ctrl));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
        chk("stall_err", 32'(stall_err), 32'(e.err));
      end
    end
  end

  function automatic exp_t reset_state();
    exp_t r;
    r.pc = 32'h0; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0;
    r.ctrl = '0; r.cnt = 16'h0; r.err = 1'b0;
    return r;
  endfunction

  // Called at a negedge: apply inputs, advance model one edge, return at next negedge.
  task automatic drive(input logic h, input logic r, input logic n,
                       input logic bt, input logic [31:0] tgt);
    exp_t nx;
    hz.hold = h; hz.repeat_i = r; hz.nop = n;
    hz.branch_taken = bt; hz.branch_target = tgt;
    id_ctrl = CW'($urandom);
    nx = m;
    nx.pc = bt ? tgt : (h ? m.pc : m.pc + 32'd4);
    if (bt) begin
      nx.instr = 32'h0; nx.pc4 = 32'h0; nx.valid = 1'b0;
    end else if (!r) begin
      nx.instr = mem_word(m.pc); nx.pc4 = m.pc + 32'd4; nx.valid = 1'b1;
    end
    nx.ctrl = (bt || n || !m.valid) ? '0 : id_ctrl;
    if (n && !bt && m.cnt != 16'hFFFF) nx.cnt = m.cnt + 16'd1;
    if (!(h == r && r == n)) nx.err = 1'b1;
    m = nx;
    expq.push_back(nx);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    m = reset_state();
    expq.push_back(m);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic free(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    hz.hold = 0; hz.repeat_i = 0; hz.nop = 0; hz.branch_taken = 0;
    hz.branch_target = 0; id_ctrl = '0;
    #3;
    @(negedge clk);
    do_reset();
    free(4);                                    // pc=0x10, ifid_pc4=0x10
    do_reset();
    free(2);                                    // pc=0x08
    drive(1, 1, 1, 0, 0);                       // one-cycle stall
    free(3);
    drive(1, 1, 1, 1, 32'h40);                  // redirect wins over stall
    free(3);
    drive(1, 0, 0, 0, 0);                       // inconsistent request
    free(3);
    drive(1, 1, 1, 0, 0);                       // three-cycle stall, reset mid-way
    drive(1, 1, 1, 0, 0);
    do_reset();
    free(3);
    // Bubble counter saturation.
    for (int i = 0; i < 65540; i++) drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 32'hFFFF_FFFC);
    free(3);                                    // pc wraps to 0
    // Random mix with a reset halfway.
    for (int i = 0; i < 400; i++) begin
      logic s, bt;
      if (i == 200) do_reset();
      s  = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0)
        drive(1'($urandom), 1'($urandom), 1'($urandom), bt, {$urandom, 2'b00} >> 0);
      else
        drive(s, s, s, bt, {30'($urandom), 2'b00});
    end
    free(2);
    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stall_ctrl.md
FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter CTRL_W, default 9, width of the decoded control bundle passed ID->EX.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port hold  input  1  hazard-unit request to freeze PC.
REQ-006 SHALL provide port repeat_i  input  1  hazard-unit request to retain the IF/ID contents.
REQ-007 SHALL provide port nop  input  1  hazard-unit request to zero the control bundle entering ID/EX.
REQ-008 SHALL provide port branch_taken  input  1  EX-stage redirect strobe.
REQ-009 SHALL provide port branch_target  input  32  redirect address.
REQ-010 SHALL provide port imem_instr  input  32  instruction word at current pc (combinational memory).
REQ-011 SHALL provide port id_ctrl  input  CTRL_W  decoder control bundle for the instruction in IF/ID.
REQ-012 SHALL provide port pc  output  32  current fetch address.
REQ-013 SHALL provide port ifid_instr  output  32  IF/ID instruction register.
REQ-014 SHALL provide port ifid_pc4  output  32  IF/ID pc+4 register.
REQ-015 SHALL provide port ifid_valid  output  1  IF/ID holds a real instruction.
REQ-016 SHALL provide port idex_ctrl  output  CTRL_W  ID/EX control register.
REQ-017 SHALL provide port bubble_cnt  output  16  count of inserted bubbles, saturating.
REQ-018 SHALL provide port stall_err  output  1  sticky flag: inconsistent stall request seen.

Function
REQ-019 PC next-value priority SHALL be: branch_taken -> branch_target; else hold -> pc unchanged; else pc+4 (modulo 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-020 IF/ID SHALL flush on branch_taken (ifid_instr=0, ifid_pc4=0, ifid_valid=0), regardless of repeat_i.
REQ-021 IF/ID SHALL retain all three fields when repeat_i=1 and branch_taken=0.
REQ-022 IF/ID SHALL otherwise load imem_instr, pc+4, valid=1 on each edge (one-cycle latency fetch->IF/ID).
REQ-023 idex_ctrl SHALL load all-zero when branch_taken=1, nop=1, or ifid_valid=0; otherwise id_ctrl (one-cycle latency).
REQ-024 bubble_cnt SHALL increment by 1 on each edge where nop=1 and branch_taken=0, saturating at 16'hFFFF.
REQ-025 stall_err SHALL set on any edge where hold, repeat_i and nop are not all equal, and remain set until reset.
REQ-026 Simultaneous branch_taken with hold/repeat_i/nop SHALL resolve in favour of branch_taken for PC, IF/ID and idex_ctrl; bubble_cnt not incremented.
REQ-027 Consecutive stall cycles SHALL each hold PC and IF/ID and each insert one bubble; release resumes at the held pc with no instruction lost or duplicated into EX.

Reset
REQ-028 On rst_n=0, asynchronously: pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, idex_ctrl=0, bubble_cnt=0, stall_err=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first edge after rst_n rises fetches RESET_PC.

Structure
REQ-030 RESET_PC default, CTRL_W default, NOP instruction value (32'h0) and bubble counter width SHALL live in the shared pipeline package.
REQ-031 IF/ID register SHALL be a sub-module ifid_reg (load/hold/flush controls); PC and ID/EX control logic stay in the top.

Verification
REQ-032 Reset then 4 free-run edges, imem returns pc-indexed words -> pc=0x10, ifid_pc4=0x10, ifid_valid=1, bubble_cnt=0.
REQ-033 At pc=0x08 assert hold=repeat_i=nop=1 for 1 cycle -> pc stays 0x08, ifid unchanged, idex_ctrl=0 next edge, bubble_cnt=1, then pc=0x0C.
REQ-034 branch_taken=1, branch_target=0x40 together with hold=repeat_i=nop=1 -> pc=0x40, ifid_valid=0, idex_ctrl=0, bubble_cnt unchanged.
REQ-035 hold=1, repeat_i=0, nop=0 one cycle -> stall_err=1 and stays 1 until rst_n=0.
REQ-036 Preload bubble_cnt near 16'hFFFE, 3 nop cycles -> bubble_cnt=16'hFFFF, no wrap; pc=0xFFFF_FFFC free-run -> pc=0.
REQ-037 Drop rst_n between edges during a 3-cycle stall -> all outputs at reset values immediately; fetch restarts at RESET_PC.
